if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage LoongArch pipeline, directly upstream of ID.

---
 rtl/if_stage.sv | 156 +++++++++++++++
 tb/tb_if_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of a 5-stage LoongArch pipeline.
//             Generates the fetch PC, issues word reads on an SRAM-like
//             request/addr_ok/data_ok bus, and hands {pc, inst} to ID through
//             a valid/allowin handshake. Applies branch redirects from ID,
//             including cancelling a wrong-path fetch that is still in flight.
//  Ports    : clk, resetn           clock / synchronous active-low reset
//             ds_allowin            ID can accept an instruction this cycle
//             br_bus[32:0]          {br_taken, br_target} from ID
//             fs_to_ds_valid        fs_to_ds_bus carries a valid instruction
//             fs_to_ds_bus[63:0]    {fs_pc, fs_inst}
//             inst_sram_*           instruction bus (read-only use)
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_br_taken;
    logic [31:0] w_br_target;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic [31:0] r_fs_inst;
    logic        r_cancel;
    logic        r_br_pend;
    logic [31:0] r_br_target;
    logic [31:0] r_seq_base;
    logic [31:0] r_req_pc;

    logic [31:0] w_nextpc;
    logic        w_req;
    logic        w_hs;
    logic        w_data_in;
    logic        w_accept;
    logic        w_handoff;

    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];

    // A live redirect wins over a remembered one, which wins over sequential.
    always_comb begin
        w_nextpc = r_seq_base + 32'd4;
        if (w_br_taken) begin
            w_nextpc = w_br_target;
        end else if (r_br_pend) begin
            w_nextpc = r_br_target;
        end
    end

    // Only request when the FS register is free or is being drained this cycle,
    // so returning data always has somewhere to land.
    assign w_req     = resetn & (r_state == S_REQ) & (~r_fs_valid | ds_allowin);
    assign w_hs      = w_req & inst_sram_addr_ok;
    assign w_data_in = (r_state == S_WAIT) & inst_sram_data_ok;
    // Data that returns during or after a redirect belongs to the wrong path.
    assign w_accept  = w_data_in & ~r_cancel & ~w_br_taken;

    assign fs_to_ds_valid = resetn & r_fs_valid & ~w_br_taken;
    assign fs_to_ds_bus   = {r_fs_pc, r_fs_inst};
    assign w_handoff      = fs_to_ds_valid & ds_allowin;

    assign inst_sram_req   = w_req;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'd0;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ:   if (w_hs)              w_state_next = S_WAIT;
            S_WAIT:  if (inst_sram_data_ok) w_state_next = S_REQ;
            default:                        w_state_next = S_REQ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fs_valid  <= 1'b0;
            r_fs_pc     <= 32'd0;
            r_fs_inst   <= 32'd0;
            r_cancel    <= 1'b0;
            r_br_pend   <= 1'b0;
            r_br_target <= 32'd0;
            r_seq_base  <= RESET_PC - 32'd4;
            r_req_pc    <= 32'd0;
        end else begin
            // A handshake consumes any pending redirect: the accepted address
            // already is the redirect target.
            if (w_hs) begin
                r_seq_base <= w_nextpc;
                r_req_pc   <= w_nextpc;
                r_br_pend  <= 1'b0;
            end else if (w_br_taken) begin
                r_br_pend   <= 1'b1;
                r_br_target <= w_br_target;
            end

            // Cancel only matters while a wrong-path read is still outstanding.
            if (w_data_in) begin
                r_cancel <= 1'b0;
            end else if ((r_state == S_WAIT) && w_br_taken) begin
                r_cancel <= 1'b1;
            end

            if (w_accept) begin
                r_fs_valid <= 1'b1;
                r_fs_pc    <= r_req_pc;
                r_fs_inst  <= inst_sram_rdata;
            end else if (w_handoff || w_br_taken) begin
                r_fs_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage: directed cycle vectors for the
//             redirect/stall/reset corner cases, then randomized bus timing,
//             back-pressure and branches checked against an instruction-stream
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rstn;
        bit          allow;
        bit          br;
        logic [31:0] tgt;
        bit          aok;
        bit          dok;
        logic [31:0] rd;
        bit          ereq;
        bit          caddr;
        logic [31:0] eaddr;
        bit          evalid;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    function automatic vec_t v(input bit rstn, input bit allow, input bit br,
                               input logic [31:0] tgt, input bit aok, input bit dok,
                               input logic [31:0] rd, input bit ereq, input bit caddr,
                               input logic [31:0] eaddr, input bit evalid,
                               input logic [31:0] epc, input logic [31:0] einst);
        vec_t t;
        t.rstn = rstn; t.allow = allow; t.br = br; t.tgt = tgt; t.aok = aok;
        t.dok = dok; t.rd = rd; t.ereq = ereq; t.caddr = caddr; t.eaddr = eaddr;
        t.evalid = evalid; t.epc = epc; t.einst = einst;
        return t;
    endfunction

    // Instruction memory contents seen by the random phase.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        resetn            = t.rstn;
        ds_allowin        = t.allow;
        br_bus            = {t.br, t.tgt};
        inst_sram_addr_ok = t.aok;
        inst_sram_data_ok = t.dok;
        inst_sram_rdata   = t.rd;
        @(negedge clk);
        check(inst_sram_req == t.ereq, $sformatf("%s_req", tag),
              64'(inst_sram_req), 64'(t.ereq));
        check(fs_to_ds_valid == t.evalid, $sformatf("%s_valid", tag),
              64'(fs_to_ds_valid), 64'(t.evalid));
        if (t.caddr)
            check(inst_sram_addr == t.eaddr, $sformatf("%s_addr", tag),
                  64'(inst_sram_addr), 64'(t.eaddr));
        if (t.evalid)
            check(fs_to_ds_bus == {t.epc, t.einst}, $sformatf("%s_bus", tag),
                  fs_to_ds_bus, {t.epc, t.einst});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I0   = 32'h0280_0421;
    localparam logic [31:0] I4   = 32'h0280_0842;
    localparam logic [31:0] D8   = 32'hdead_0008;
    localparam logic [31:0] R100 = 32'h1111_0100;
    localparam logic [31:0] R200 = 32'h2222_0200;
    localparam logic [31:0] R300 = 32'h3333_0300;
    localparam logic [31:0] R400 = 32'h4444_0400;

    initial begin
        vec_t        tbl [$];
        vec_t        seq [$];
        bit          pend;
        logic [31:0] pend_addr;
        int unsigned dly;
        logic [31:0] exp_pc;
        bit          prev_stall;
        logic [63:0] prev_bus;
        bit          prev_br;
        int          handoffs;
        bit          hs;
        logic [31:0] hs_addr;
        logic [31:0] tgt;

        resetn = 1'b0; ds_allowin = 1'b0; br_bus = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Directed stream: fetch, stall, redirect in WAIT, redirect at handshake,
        // redirect while addr_ok is held low.
        //            rstn al br tgt           aok dok rd     req ca addr          val pc            inst
        tbl.push_back(v(0, 1, 0, 0,             1, 0, 0,     0, 0, 0,             0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000000,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 1, I0,    0, 1, 32'h1c000004,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000004,  1, 32'h1c000000, I0));
        tbl.push_back(v(1, 0, 0, 0,             0, 1, I4,    0, 1, 32'h1c000008,  0, 0,            0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 0, 0, 0,         1, 0, 0,     0, 1, 32'h1c000008,  1, 32'h1c000004, I4));
        tbl.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000008,  1, 32'h1c000004, I4));
        tbl.push_back(v(1, 1, 1, 32'h1c000100,  0, 0, 0,     0, 1, 32'h1c000100,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     0, 1, 32'h1c000100,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 1, D8,    0, 1, 32'h1c000100,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000100,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 1, R100,  0, 1, 32'h1c000104,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000104,  1, 32'h1c000100, R100));
        tbl.push_back(v(1, 1, 1, 32'h1c000200,  1, 0, 0,     1, 1, 32'h1c000200,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 1, R200,  0, 1, 32'h1c000204,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000204,  1, 32'h1c000200, R200));
        tbl.push_back(v(1, 1, 1, 32'h1c000300,  0, 0, 0,     1, 1, 32'h1c000300,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000300,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000300,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000300,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 1, R300,  0, 1, 32'h1c000304,  0, 0,            0));
        tbl.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000304,  1, 32'h1c000300, R300));

        check(inst_sram_wr == 1'b0 && inst_sram_size == 2'b10 &&
              inst_sram_wstrb == 4'd0 && inst_sram_wdata == 32'd0, "tieoffs",
              {27'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
              64'h0000_0020_0000_0000);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a read is outstanding, then data_ok coinciding with a
        // branch, then a branch while a stalled instruction is held.
        seq.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000304,  0, 0,            0));
        seq.push_back(v(0, 1, 0, 0,             0, 0, 0,     0, 0, 0,             0, 0,            0));
        seq.push_back(v(1, 1, 0, 0,             0, 0, 0,     1, 1, 32'h1c000000,  0, 0,            0));
        seq.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000000,  0, 0,            0));
        seq.push_back(v(1, 1, 1, 32'h1c000400,  0, 1, I0,    0, 1, 32'h1c000400,  0, 0,            0));
        seq.push_back(v(1, 1, 0, 0,             1, 0, 0,     1, 1, 32'h1c000400,  0, 0,            0));
        seq.push_back(v(1, 0, 0, 0,             0, 1, R400,  0, 1, 32'h1c000404,  0, 0,            0));
        seq.push_back(v(1, 0, 0, 0,             1, 0, 0,     0, 1, 32'h1c000404,  1, 32'h1c000400, R400));
        seq.push_back(v(1, 0, 1, 32'h1c000500,  1, 0, 0,     0, 1, 32'h1c000500,  0, 0,            0));
        seq.push_back(v(1, 0, 0, 0,             0, 0, 0,     1, 1, 32'h1c000500,  0, 0,            0));
        for (int i = 0; i < seq.size(); i++)
            apply(seq[i], $sformatf("seq%0d", i));

        // Random phase: the delivered stream must be RESET_PC, +4, +4, ...
        // restarting at each branch target, with correct memory contents.
        resetn = 1'b0; br_bus = '0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        pend = 1'b0; pend_addr = '0; dly = 0;
        exp_pc = RESET_PC; prev_stall = 1'b0; prev_bus = '0; prev_br = 1'b0; handoffs = 0;

        for (int c = 0; c < 4000; c++) begin
            ds_allowin        = ($urandom_range(0, 3) != 0);
            inst_sram_addr_ok = 1'($urandom_range(0, 1));
            if (!prev_br && $urandom_range(0, 11) == 0) begin
                tgt    = RESET_PC + ($urandom_range(0, 1023) << 2);
                br_bus = {1'b1, tgt};
            end else begin
                br_bus = {1'b0, $urandom()};
            end
            inst_sram_data_ok = pend && (dly == 0);
            inst_sram_rdata   = inst_sram_data_ok ? mem(pend_addr) : $urandom();

            @(negedge clk);
            hs      = inst_sram_req & inst_sram_addr_ok;
            hs_addr = inst_sram_addr;
            if (inst_sram_req && pend)
                check(1'b0, "one_outstanding", 64'(inst_sram_req), 64'd0);
            if (prev_stall && !br_bus[32])
                check(fs_to_ds_valid && fs_to_ds_bus == prev_bus, "stall_hold",
                      fs_to_ds_bus, prev_bus);
            if (br_bus[32])
                check(!fs_to_ds_valid, "br_kill", 64'(fs_to_ds_valid), 64'd0);
            if (fs_to_ds_valid && ds_allowin) begin
                check(fs_to_ds_bus[63:32] == exp_pc, "stream_pc",
                      64'(fs_to_ds_bus[63:32]), 64'(exp_pc));
                check(fs_to_ds_bus[31:0] == mem(exp_pc), "stream_inst",
                      64'(fs_to_ds_bus[31:0]), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                handoffs++;
            end
            if (br_bus[32])
                exp_pc = br_bus[31:0];
            prev_stall = fs_to_ds_valid & ~ds_allowin;
            prev_bus   = fs_to_ds_bus;
            prev_br    = br_bus[32];

            @(posedge clk);
            #1;
            if (pend) begin
                if (dly == 0) pend = 1'b0;
                else          dly  = dly - 1;
            end
            if (hs) begin
                pend      = 1'b1;
                pend_addr = hs_addr;
                dly       = $urandom_range(0, 2);
            end
        end

        check(handoffs >= 200, "progress", 64'(handoffs), 64'd200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
